irq_controller: RTL

- Parametrised interrupt aggregator placed in front of the CPU core's i_irq_x / i_nmi_x pins.
- Replaces the single hard-wired IRQ/NMI line pair with NUM_IRQ maskable sources, each selectable as level- or edge-triggered, plus one edge-triggered NMI source.
- Produces the active-low o_irq_x / o_nmi_x the core expects, and exposes a 4-register, 8-bit bus window so the ISR can read a prioritised vector id and acknowledge it.

---
 rtl/irq_controller_if.sv | 17 +
 rtl/irq_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/irq_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller_if
// Brief    : 8-bit, 4-register bus window into the interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_controller_if;
    logic       i_cs;
    logic       i_we;
    logic [1:0] i_addr;
    logic [7:0] i_wdata;
    logic [7:0] o_rdata;

    modport master (output i_cs, i_we, i_addr, i_wdata, input  o_rdata);
    modport slave  (input  i_cs, i_we, i_addr, i_wdata, output o_rdata);
endinterface
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Brief    : Maskable level/edge IRQ aggregator with prioritised vector read
//            and a queued, pulse-stretched edge-triggered NMI.
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int NMI_PULSE   = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [NUM_IRQ-1:0] i_src,
    input  wire logic               i_nmi_src,
    irq_controller_if.slave         bus,
    output logic                    o_irq_x,
    output logic                    o_nmi_x
);

    localparam logic [1:0] c_ADDR_PEND   = 2'd0;
    localparam logic [1:0] c_ADDR_MASK   = 2'd1;
    localparam logic [1:0] c_ADDR_MODE   = 2'd2;
    localparam logic [1:0] c_ADDR_VECTOR = 2'd3;

    // Bit 0 of the state doubles as the active-high NMI drive.
    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_LOW  = 2'b01;
    localparam logic [1:0] c_ST_GAP  = 2'b10;

    localparam logic [3:0] c_PULSE_LAST = 4'(NMI_PULSE - 1);

    logic [NUM_IRQ:0]   r_sync [SYNC_STAGES];
    logic [NUM_IRQ:0]   r_s_prev;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_mode;
    logic [7:0]         r_rdata;
    logic               r_irq_x;
    logic [1:0]         r_nmi_state;
    logic [3:0]         r_nmi_cnt;
    logic               r_nmi_queued;

    logic [NUM_IRQ:0]   w_s;
    logic [NUM_IRQ:0]   w_rise;
    logic               w_nmi_rise;
    logic               w_rd;
    logic               w_wr;
    logic [NUM_IRQ-1:0] w_wdata_n;
    logic [NUM_IRQ-1:0] w_active;
    logic               w_valid;
    logic [2:0]         w_id;
    logic               w_ack;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_pend_next;
    logic [7:0]         w_rd_mux;

    // Index NUM_IRQ of the synchroniser and edge history carries the NMI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_s_prev <= '0;
        end else begin
            r_sync[0] <= {i_nmi_src, i_src};
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_s_prev <= w_s;
        end
    end

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_s & ~r_s_prev;
    assign w_nmi_rise = w_rise[NUM_IRQ];

    assign w_rd      = bus.i_cs & ~bus.i_we;
    assign w_wr      = bus.i_cs &  bus.i_we;
    assign w_wdata_n = bus.i_wdata[NUM_IRQ-1:0];
    assign w_active  = r_pend & r_mask;
    assign w_valid   = |w_active;
    assign w_ack     = w_rd && (bus.i_addr == c_ADDR_VECTOR) && w_valid;

    always_comb begin
        w_id = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_id = 3'(i);
            end
        end
    end

    // Clear sources for edge-mode pend bits: W1C, acknowledge, edge->level switch.
    always_comb begin
        w_clr = '0;
        if (w_wr && (bus.i_addr == c_ADDR_PEND)) begin
            w_clr = w_clr | (w_wdata_n & r_mode);
        end
        if (w_wr && (bus.i_addr == c_ADDR_MODE)) begin
            w_clr = w_clr | (r_mode & ~w_wdata_n);
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_ack && (w_id == 3'(i)) && r_mode[i]) begin
                w_clr[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_pend_next[i] = r_mode[i] ? (w_rise[i] | (r_pend[i] & ~w_clr[i]))
                                       : w_s[i];
        end
    end

    always_comb begin
        case (bus.i_addr)
            c_ADDR_PEND:   w_rd_mux = 8'(r_pend);
            c_ADDR_MASK:   w_rd_mux = 8'(r_mask);
            c_ADDR_MODE:   w_rd_mux = 8'(r_mode);
            c_ADDR_VECTOR: w_rd_mux = w_valid ? {1'b1, 4'b0000, w_id} : 8'h00;
            default:       w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_mask  <= '0;
            r_mode  <= '0;
            r_rdata <= 8'h00;
            r_irq_x <= 1'b1;
        end else begin
            r_pend  <= w_pend_next;
            r_irq_x <= ~w_valid;
            if (w_wr && (bus.i_addr == c_ADDR_MASK)) begin
                r_mask <= w_wdata_n;
            end
            if (w_wr && (bus.i_addr == c_ADDR_MODE)) begin
                r_mode <= w_wdata_n;
            end
            if (w_rd) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    // NMI pulse generator: one-deep queue guarantees a high gap between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_nmi_state  <= c_ST_IDLE;
            r_nmi_cnt    <= 4'd0;
            r_nmi_queued <= 1'b0;
        end else begin
            case (r_nmi_state)
                c_ST_IDLE: begin
                    if (w_nmi_rise) begin
                        r_nmi_state <= c_ST_LOW;
                        r_nmi_cnt   <= c_PULSE_LAST;
                    end
                end
                c_ST_LOW: begin
                    if (w_nmi_rise) begin
                        r_nmi_queued <= 1'b1;
                    end
                    if (r_nmi_cnt == 4'd0) begin
                        r_nmi_state <= c_ST_GAP;
                    end else begin
                        r_nmi_cnt <= r_nmi_cnt - 4'd1;
                    end
                end
                c_ST_GAP: begin
                    if (r_nmi_queued || w_nmi_rise) begin
                        r_nmi_state  <= c_ST_LOW;
                        r_nmi_cnt    <= c_PULSE_LAST;
                        r_nmi_queued <= 1'b0;
                    end else begin
                        r_nmi_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_nmi_state  <= c_ST_IDLE;
                    r_nmi_queued <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_rdata = r_rdata;
    assign o_irq_x     = r_irq_x;
    assign o_nmi_x     = ~r_nmi_state[0];

endmodule
`default_nettype wire
